// File: rtl/qea_host_ctrl.sv
// Host-side sequencer for the QEA core: loads gate context and packed state rows,
// starts the core, times its execution and streams the resulting state back out.
module qea_host_ctrl #(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int RD_LATENCY              = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_cfg_valid,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic                                 i_s_valid,
    output logic                                 o_s_ready,
    input  logic [63:0]                          i_s_data,
    output logic                                 o_m_valid,
    input  logic                                 i_m_ready,
    output logic [63:0]                          o_m_data,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
    output logic                                 o_start,
    input  logic                                 i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic [31:0]                          o_exec_cycles
);
    localparam int SDW = STATE_DATA_WIDTH;
    localparam int RW  = PE_NUM * SDW;
    localparam int BW  = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam int LW  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, LD_CTX, LD_STATE, START, RUN, RD_REQ, RD_WAIT, RD_OUT} state_t;

    state_t                         state_q;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_num_q, ctx_idx_q, ctx_addr_q;
    logic [STATE_ADDR_WIDTH-1:0]    last_row_q, row_idx_q, st_addr_q;
    logic [BW-1:0]                  beat_q;
    logic [LW-1:0]                  lat_q;
    logic [RW-1:0]                  pack_q, shift_q, st_din_q;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q;
    logic [63:0]                    m_data_q;
    logic [MAX_QBIT_WIDTH-1:0]      qbit_q;
    logic [31:0]                    exec_q;
    logic                           first_run_q, s_ready_q, m_valid_q, ctx_en_q;
    logic                           st_ena_q, st_wea_q, start_q, busy_q, done_q, err_q;

    logic                           s_acc, m_acc, cfg_bad_d;
    logic [MAX_QBIT_WIDTH-1:0]      qm2_d;
    logic [STATE_ADDR_WIDTH:0]      rows_d;
    logic [RW-1:0]                  row_d, sh_next_d;
    logic [31:0]                    exec_d;

    assign s_acc     = i_s_valid && s_ready_q;
    assign m_acc     = m_valid_q && i_m_ready;
    assign cfg_bad_d = (i_qbit_num < MAX_QBIT_WIDTH'(2)) ||
                       (i_qbit_num > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2));
    assign qm2_d     = i_qbit_num - MAX_QBIT_WIDTH'(2);
    assign rows_d    = {{STATE_ADDR_WIDTH{1'b0}}, 1'b1} << qm2_d;
    // New beat enters the low slice, so the first beat of a row ends up on top.
    assign row_d     = RW'({pack_q, i_s_data});
    assign sh_next_d = shift_q << SDW;
    assign exec_d    = (exec_q == '1) ? exec_q : exec_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;       ins_num_q <= '0;   ctx_idx_q <= '0;  ctx_addr_q <= '0;
            last_row_q <= '0;      row_idx_q <= '0;   st_addr_q <= '0;  beat_q <= '0;
            lat_q <= '0;           pack_q <= '0;      shift_q <= '0;    st_din_q <= '0;
            ctx_data_q <= '0;      m_data_q <= '0;    qbit_q <= '0;     exec_q <= '0;
            first_run_q <= 1'b0;   s_ready_q <= 1'b0; m_valid_q <= 1'b0; ctx_en_q <= 1'b0;
            st_ena_q <= 1'b0;      st_wea_q <= 1'b0;  start_q <= 1'b0;  busy_q <= 1'b0;
            done_q <= 1'b0;        err_q <= 1'b0;
        end else begin
            ctx_en_q <= 1'b0;
            st_ena_q <= 1'b0;
            st_wea_q <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: if (i_cfg_valid) begin
                    if (cfg_bad_d) begin
                        err_q <= 1'b1;
                    end else begin
                        ins_num_q  <= i_ins_num;
                        qbit_q     <= i_qbit_num;
                        last_row_q <= STATE_ADDR_WIDTH'(rows_d - 1'b1);
                        ctx_idx_q  <= '0;
                        row_idx_q  <= '0;
                        beat_q     <= '0;
                        busy_q     <= 1'b1;
                        s_ready_q  <= 1'b1;
                        state_q    <= (i_ins_num == '0) ? LD_STATE : LD_CTX;
                    end
                end
                LD_CTX: if (s_acc) begin
                    ctx_en_q   <= 1'b1;
                    ctx_addr_q <= ctx_idx_q;
                    ctx_data_q <= i_s_data;
                    ctx_idx_q  <= ctx_idx_q + 1'b1;
                    if (ctx_idx_q == ins_num_q - 1'b1) state_q <= LD_STATE;
                end
                LD_STATE: if (s_acc) begin
                    pack_q <= row_d;
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == BW'(PE_NUM - 1)) begin
                        beat_q    <= '0;
                        st_ena_q  <= 1'b1;
                        st_wea_q  <= 1'b1;
                        st_din_q  <= row_d;
                        st_addr_q <= row_idx_q;
                        row_idx_q <= row_idx_q + 1'b1;
                        if (row_idx_q == last_row_q) begin
                            row_idx_q <= '0;
                            s_ready_q <= 1'b0;
                            start_q   <= 1'b1;
                            exec_q    <= '0;
                            state_q   <= START;
                        end
                    end
                end
                START: begin
                    exec_q      <= exec_d;
                    first_run_q <= 1'b1;
                    state_q     <= RUN;
                end
                RUN: begin
                    first_run_q <= 1'b0;
                    // A completion level left over from a previous job is ignored in the first RUN cycle.
                    if (!first_run_q && i_complete) begin
                        st_ena_q  <= 1'b1;
                        st_addr_q <= row_idx_q;
                        state_q   <= RD_REQ;
                    end else begin
                        exec_q <= exec_d;
                    end
                end
                RD_REQ: begin
                    lat_q   <= '0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: if (lat_q == LW'(RD_LATENCY - 1)) begin
                    shift_q   <= i_state_dout;
                    m_data_q  <= i_state_dout[RW-1 -: 64];
                    m_valid_q <= 1'b1;
                    beat_q    <= '0;
                    state_q   <= RD_OUT;
                end else begin
                    lat_q <= lat_q + 1'b1;
                end
                RD_OUT: if (m_acc) begin
                    if (beat_q == BW'(PE_NUM - 1)) begin
                        m_valid_q <= 1'b0;
                        if (row_idx_q == last_row_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            row_idx_q <= row_idx_q + 1'b1;
                            st_ena_q  <= 1'b1;
                            st_addr_q <= row_idx_q + 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end else begin
                        beat_q   <= beat_q + 1'b1;
                        shift_q  <= sh_next_d;
                        m_data_q <= sh_next_d[RW-1 -: 64];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_s_ready     = s_ready_q;
    assign o_m_valid     = m_valid_q;
    assign o_m_data      = m_data_q;
    assign o_ctx_en      = ctx_en_q;
    assign o_ctx_wea     = ctx_en_q;
    assign o_ctx_addr    = ctx_addr_q;
    assign o_ctx_data    = ctx_data_q;
    assign o_state_ena   = st_ena_q;
    assign o_state_wea   = st_wea_q;
    assign o_state_addra = st_addr_q;
    assign o_state_dina  = st_din_q;
    assign o_qbit_num    = qbit_q;
    assign o_start       = start_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign o_exec_cycles = exec_q;
endmodule

// File: tb/tb_qea_host_ctrl.sv
// Directed bench for qea_host_ctrl: queue-based expectations for every RAM access and
// output beat, plus literal checks on reset, timing of start/run and error handling.
module tb_qea_host_ctrl;
    logic         clk = 1'b0, rst = 1'b1;
    logic         i_cfg_valid = 1'b0;
    logic [15:0]  i_ins_num = '0;
    logic [5:0]   i_qbit_num = '0;
    logic         i_s_valid = 1'b0, o_s_ready;
    logic [63:0]  i_s_data = '0;
    logic         o_m_valid, i_m_ready = 1'b1;
    logic [63:0]  o_m_data;
    logic         o_ctx_en, o_ctx_wea;
    logic [15:0]  o_ctx_addr;
    logic [63:0]  o_ctx_data;
    logic         o_state_ena, o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] o_state_dina;
    logic [5:0]   o_qbit_num;
    logic         o_start, i_complete = 1'b0;
    logic [255:0] i_state_dout = '0;
    logic         o_busy, o_done, o_err;
    logic [31:0]  o_exec_cycles;

    qea_host_ctrl dut (
        .clk(clk), .rst(rst), .i_cfg_valid(i_cfg_valid), .i_ins_num(i_ins_num),
        .i_qbit_num(i_qbit_num), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
        .i_s_data(i_s_data), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
        .o_m_data(o_m_data), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
        .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena),
        .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .o_qbit_num(o_qbit_num), .o_start(o_start),
        .i_complete(i_complete), .i_state_dout(i_state_dout), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err), .o_exec_cycles(o_exec_cycles)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int n_start = 0, n_done = 0, n_err = 0;
    logic tog_en = 1'b0;

    // Expected transactions, in order.
    logic [15:0]  q_ca[$];
    logic [63:0]  q_cd[$];
    logic [15:0]  q_sa[$];
    logic [255:0] q_sd[$];
    logic [15:0]  q_ra[$];
    logic [63:0]  q_b[$];

    logic [255:0] rdmem [2];
    logic [63:0]  sb [8];
    logic [255:0] st_first = '0;
    logic [63:0]  m_first = '0;
    bit           st_seen = 0, m_seen = 0;
    logic         pv = 1'b0, pr = 1'b0;
    logic [63:0]  pd = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // QEA state RAM read port with one cycle of latency.
    always @(posedge clk)
        if (o_state_ena && !o_state_wea)
            i_state_dout <= (o_state_addra < 16'd2) ? rdmem[o_state_addra[0]] : '0;

    initial forever begin
        @(posedge clk);
        #1;
        i_m_ready = tog_en ? ~i_m_ready : 1'b1;
    end

    always @(negedge clk) begin
        if (o_ctx_en) begin
            if (q_ca.size() == 0) chk("ctx_unexpected", 1, 0);
            else begin
                chk("ctx_addr", o_ctx_addr, q_ca.pop_front());
                chk("ctx_data", o_ctx_data, q_cd.pop_front());
                chk("ctx_wea", o_ctx_wea, 1);
            end
        end
        if (o_state_ena && o_state_wea) begin
            if (!st_seen) begin st_first = o_state_dina; st_seen = 1; end
            if (q_sa.size() == 0) chk("st_wr_unexpected", 1, 0);
            else begin
                chk("st_wr_addr", o_state_addra, q_sa.pop_front());
                chk("st_wr_data", o_state_dina, q_sd.pop_front());
            end
        end
        if (o_state_ena && !o_state_wea) begin
            if (q_ra.size() == 0) chk("st_rd_unexpected", 1, 0);
            else chk("st_rd_addr", o_state_addra, q_ra.pop_front());
        end
        if (pv && !pr) begin
            chk("stall_valid", o_m_valid, 1);
            chk("stall_data", o_m_data, pd);
        end
        if (o_m_valid && i_m_ready) begin
            if (!m_seen) begin m_first = o_m_data; m_seen = 1; end
            if (q_b.size() == 0) chk("beat_unexpected", 1, 0);
            else chk("beat_data", o_m_data, q_b.pop_front());
        end
        pv = o_m_valid; pr = i_m_ready; pd = o_m_data;
        if (o_start) n_start++;
        if (o_done) n_done++;
        if (o_err) n_err++;
    end

    function automatic logic [63:0] ctxw(input int i);
        return {32'hC0DE0000 + 32'(i), 32'(i * 7 + 1)};
    endfunction

    task automatic cfg(input int ins, input int qb);
        @(negedge clk);
        i_cfg_valid = 1'b1; i_ins_num = 16'(ins); i_qbit_num = 6'(qb);
        @(negedge clk);
        i_cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input int gap, output int waited);
        waited = 0;
        repeat (gap) begin @(negedge clk); i_s_valid = 1'b0; end
        @(negedge clk);
        i_s_valid = 1'b1; i_s_data = d;
        while (!o_s_ready && waited < 1000) begin @(negedge clk); waited++; end
        if (waited >= 1000) chk("s_ready_timeout", 0, 1);
    endtask

    task automatic run_job(input int ins, input int qb, input int delay, input bit extras);
        int rows, w, stalls, n;
        rows = 1 << (qb - 2);
        cfg(ins, qb);
        chk("cfg_busy", o_busy, 1);
        chk("cfg_qbit", o_qbit_num, qb);
        for (int i = 0; i < ins; i++) begin q_ca.push_back(16'(i)); q_cd.push_back(ctxw(i)); end
        for (int r = 0; r < rows; r++) begin
            q_sa.push_back(16'(r));
            q_sd.push_back({sb[4*r], sb[4*r+1], sb[4*r+2], sb[4*r+3]});
            q_ra.push_back(16'(r));
            for (int b = 0; b < 4; b++) q_b.push_back(rdmem[r][255 - 64*b -: 64]);
        end
        for (int i = 0; i < ins; i++) send(ctxw(i), $urandom_range(0, 2), w);
        stalls = 0;
        for (int i = 0; i < 4 * rows; i++) begin send(sb[i], 0, w); stalls += w; end
        @(negedge clk);
        i_s_valid = 1'b0;
        n = 0;
        while (!o_start && n < 1000) begin @(negedge clk); n++; end
        chk("start_seen", o_start, 1);
        chk("state_no_bubble", stalls, 0);
        chk("s_ready_drop", o_s_ready, 0);
        chk("exec_clear", o_exec_cycles, 0);
        tog_en = 1'b1;
        if (extras) begin
            i_complete = 1'b1;
            @(negedge clk);
            i_complete = 1'b0;
            chk("exec_first_run", o_exec_cycles, 1);
            repeat (9) @(negedge clk);
            i_cfg_valid = 1'b1; i_ins_num = 16'd5; i_qbit_num = 6'd1;
            @(negedge clk);
            i_cfg_valid = 1'b0;
            chk("cfg_in_run_err", o_err, 0);
            chk("cfg_in_run_busy", o_busy, 1);
            repeat (delay - 11) @(negedge clk);
        end else begin
            repeat (delay) @(negedge clk);
        end
        i_complete = 1'b1;
        repeat (2) @(negedge clk);
        chk("exec_frozen", o_exec_cycles, delay);
        n = 0;
        while (!o_done && n < 2000) begin @(negedge clk); n++; end
        chk("done_seen", o_done, 1);
        chk("done_busy_low", o_busy, 0);
        chk("done_exec", o_exec_cycles, delay);
        i_complete = 1'b0;
        tog_en = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", o_done, 0);
        chk("beats_left", q_b.size(), 0);
    endtask

    initial begin
        int w;
        rdmem[0] = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        rdmem[1] = {64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002,
                    64'hCCCC_0000_0000_0003, 64'hDDDD_0000_0000_0004};
        repeat (3) @(negedge clk);
        chk("rst_ctl", {o_busy, o_s_ready, o_m_valid, o_start, o_done, o_err,
                        o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea}, 0);
        chk("rst_exec", o_exec_cycles, 0);
        chk("rst_qbit", o_qbit_num, 0);
        rst = 1'b0;

        cfg(5, 1);
        chk("err_qbit1", o_err, 1);
        chk("err_busy", o_busy, 0);
        chk("err_qbit_hold", o_qbit_num, 0);
        @(negedge clk);
        chk("err_one_cycle", o_err, 0);
        cfg(0, 19);
        chk("err_qbit19", o_err, 1);
        chk("err_no_ready", o_s_ready, 0);

        sb[0] = 64'h4000_0000_0000_0000;
        for (int i = 1; i < 8; i++) sb[i] = '0;
        run_job(149, 3, 57, 1'b1);
        chk("row0_literal", st_first, {64'h4000_0000_0000_0000, 192'h0});
        chk("beat0_literal", m_first, 64'h1111_1111_1111_1111);

        // Abort a load after three of eight state beats.
        cfg(0, 3);
        for (int i = 0; i < 3; i++) send(64'hDEAD_0000_0000_0000 + 64'(i), 0, w);
        @(negedge clk);
        i_s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_ctl", {o_busy, o_s_ready, o_m_valid, o_start, o_done, o_err,
                          o_ctx_en, o_state_ena, o_state_wea}, 0);
        chk("abort_exec", o_exec_cycles, 0);
        chk("abort_qbit", o_qbit_num, 0);
        chk("abort_dina", o_state_dina, 0);
        @(negedge clk);
        rst = 1'b0;

        sb[0] = 64'h0123_4567_89AB_CDEF; sb[1] = 64'hFEDC_BA98_7654_3210;
        sb[2] = 64'h0F0F_0F0F_0F0F_0F0F; sb[3] = 64'hF0F0_F0F0_F0F0_F0F0;
        run_job(2, 2, 5, 1'b0);

        repeat (3) @(negedge clk);
        chk("ctx_left", q_ca.size(), 0);
        chk("st_wr_left", q_sa.size(), 0);
        chk("st_rd_left", q_ra.size(), 0);
        chk("start_count", n_start, 2);
        chk("done_count", n_done, 2);
        chk("err_count", n_err, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
